gpr_seq_ctrl: RTL and testbench

// - Command sequencer for the 2-entry bit-serial GPR file (rx/ry, LSB-first shift-right registers).
// - Accepts one command per valid/ready handshake: CLR, LOAD, ROT or ADD on one register.
// - Drives the GPR shift-enable, write-enable, serial data-in and register select for WIDTH cycles.
// - Computes bit-serial results (ADD carry chain) from the GPR's serial LSB output.

---
 rtl/gpr_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_gpr_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_seq_ctrl.sv
// Command sequencer for a 2-entry bit-serial GPR file (CLR/LOAD/ROT/ADD, LSB first).
// Optional zero flag output o_zero is built when GPR_SEQ_ZFLAG_EN is defined.
module gpr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic             i_cmd_addr,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic             i_gpr_bit,
  output logic             o_con_shift,
  output logic             o_con_write,
  output logic             o_data_in,
  output logic             o_rd_addr,
  output logic             o_ser_bit,
  output logic             o_ser_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry
`ifdef GPR_SEQ_ZFLAG_EN
  ,
  output logic             o_zero
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] OP_CLR  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_ROT  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op;
  logic             addr;
  logic [WIDTH-1:0] opnd;
  logic             carry;
  logic             accept, run, last, wbit;

  assign accept = i_cmd_valid && (state == IDLE);
  assign run    = (state == RUN);
  assign last   = (cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cmd_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Serial bit written into the GPR this cycle; CLR relies on write-enable low.
  always_comb begin
    wbit = 1'b0;
    case (op)
      OP_CLR:  wbit = 1'b0;
      OP_LOAD: wbit = opnd[0];
      OP_ROT:  wbit = i_gpr_bit;
      OP_ADD:  wbit = i_gpr_bit ^ opnd[0] ^ carry;
      default: wbit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt   <= '0;
      op    <= OP_CLR;
      addr  <= 1'b0;
      opnd  <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      op    <= i_cmd_op;
      addr  <= i_cmd_addr;
      opnd  <= i_cmd_data;
      carry <= 1'b0;
    end else if (run) begin
      cnt  <= cnt + CNT_W'(1);
      opnd <= {1'b0, opnd[WIDTH-1:1]};
      if (op == OP_ADD)
        carry <= (i_gpr_bit & opnd[0]) | (i_gpr_bit & carry) | (opnd[0] & carry);
    end
  end

  assign o_cmd_ready = (state == IDLE);
  assign o_con_shift = run;
  assign o_con_write = run && (op != OP_CLR);
  assign o_data_in   = run && wbit;
  assign o_rd_addr   = addr;
  assign o_ser_bit   = run && i_gpr_bit;
  assign o_ser_valid = run;
  assign o_busy      = (state == RUN) || (state == DONE);
  assign o_done      = (state == DONE);
  assign o_carry     = carry;

`ifdef GPR_SEQ_ZFLAG_EN
  // zacc accumulates "all written bits zero"; zflag publishes it at the last shift.
  logic zacc, zflag;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      zacc  <= 1'b0;
      zflag <= 1'b0;
    end else if (accept) begin
      zacc  <= 1'b1;
      zflag <= 1'b0;
    end else if (run) begin
      zacc <= zacc & ~o_data_in;
      if (last) zflag <= zacc & ~o_data_in;
    end
  end
  assign o_zero = zflag;
`endif

endmodule

// File: tb/tb_gpr_seq_ctrl.sv
// Bench for gpr_seq_ctrl: directed table, back-to-back, mid-command reset and random
// commands checked against a word-level model of the register file.
module tb_gpr_seq_ctrl;
  localparam int W = 8;
  localparam logic [1:0] CLR = 2'b00, LOAD = 2'b01, ROT = 2'b10, ADD = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_addr, gpr_bit;
  logic [1:0] cmd_op;
  logic [W-1:0] cmd_data;
  logic con_shift, con_write, data_in, rd_addr, ser_bit, ser_valid, busy, done, carry;
`ifdef GPR_SEQ_ZFLAG_EN
  logic zero;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpr_seq_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_gpr_bit(gpr_bit),
    .o_con_shift(con_shift), .o_con_write(con_write), .o_data_in(data_in),
    .o_rd_addr(rd_addr), .o_ser_bit(ser_bit), .o_ser_valid(ser_valid), .o_busy(busy),
    .o_done(done), .o_carry(carry)
`ifdef GPR_SEQ_ZFLAG_EN
    , .o_zero(zero)
`endif
  );

  // Bit-serial GPR file the controller drives (shift-right, LSB out, not reset).
  logic [W-1:0] gpr [2];
  always @(posedge clk)
    if (con_shift) gpr[rd_addr] <= {con_write ? data_in : 1'b0, gpr[rd_addr][W-1:1]};
  assign gpr_bit = gpr[rd_addr][0];

  logic [W-1:0] mdl [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk(nm, {22'd0, cmd_ready, con_shift, con_write, data_in, rd_addr, ser_bit, ser_valid,
             busy, done, carry}, 32'h200);
`ifdef GPR_SEQ_ZFLAG_EN
    chk({nm, "_zero"}, {31'd0, zero}, 32'd0);
`endif
  endtask

  // Issue one command and check the whole transaction against word-level expectations.
  task automatic run_check(input string nm, input logic [1:0] op, input logic a,
                           input logic [W-1:0] d, input logic [W-1:0] exp_reg,
                           input logic exp_c, input logic exp_z);
    logic [W-1:0] ser, old;
    int nsh, ndn, ncyc, badaddr;
    ser = '0; nsh = 0; ndn = 0; ncyc = 0; badaddr = 0;
    @(negedge clk);
    chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    old = gpr[a];
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 1'($urandom); cmd_data = W'($urandom);
    while (ndn == 0 && ncyc < 40) begin
      @(negedge clk);
      ncyc++;
      if (con_shift) begin
        if (nsh < W) ser[nsh] = ser_bit;
        nsh++;
        if (rd_addr !== a) badaddr++;
      end
      if (done) ndn++;
    end
    chk({nm, "_shifts"}, nsh, W);
    chk({nm, "_latency"}, ncyc, W + 1);
    chk({nm, "_addr"}, badaddr, 0);
    chk({nm, "_ser"}, {24'd0, ser}, {24'd0, old});
    chk({nm, "_carry"}, {31'd0, carry}, {31'd0, exp_c});
`ifdef GPR_SEQ_ZFLAG_EN
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
`else
    if (exp_z === 1'bx) $display("note: zero expectation undefined");
`endif
    @(negedge clk);
    chk({nm, "_donepulse"}, {30'd0, done, rd_addr}, {30'd0, 1'b0, a});
    chk({nm, "_reg"}, {24'd0, gpr[a]}, {24'd0, exp_reg});
    mdl[a] = exp_reg;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic         addr;
    logic [W-1:0] data;
    logic [W-1:0] exp_reg;
    logic         exp_c;
    logic         exp_z;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int nacc, nlow, t0, t1, ndn, bad;
    logic [1:0] op;
    logic a;
    logic [W-1:0] d, nv;
    logic [W:0] sum;

    tbl[0] = '{LOAD, 1'b1, 8'hA5, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{ROT,  1'b1, 8'h3C, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{LOAD, 1'b0, 8'hF0, 8'hF0, 1'b0, 1'b0};
    tbl[3] = '{ADD,  1'b0, 8'h20, 8'h10, 1'b1, 1'b0};
    tbl[4] = '{LOAD, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
    tbl[5] = '{ADD,  1'b0, 8'h01, 8'h02, 1'b0, 1'b0};
    tbl[6] = '{CLR,  1'b1, 8'h5A, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{LOAD, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};
    tbl[8] = '{ADD,  1'b1, 8'hFF, 8'h00, 1'b1, 1'b1};
    tbl[9] = '{ROT,  1'b0, 8'hFF, 8'h02, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 1'b0; cmd_data = '0;
    #12;
    chk_idle("reset");
    @(negedge clk); rst = 1'b0;

    foreach (tbl[i])
      run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].data,
                tbl[i].exp_reg, tbl[i].exp_c, tbl[i].exp_z);

    // Back-to-back: valid held high across two commands.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_addr = 1'b0; cmd_data = 8'h3C;
    nacc = 0; nlow = 0; t0 = 0; t1 = 0; bad = 0;
    for (int k = 0; k < 30; k++) begin
      if (cmd_valid && cmd_ready) begin
        if (nacc == 0) t0 = k; else t1 = k;
        nacc++;
      end else if (cmd_valid) nlow++;
      if (cmd_ready == busy) bad++;
      @(posedge clk); #1;
      if (nacc == 1) begin cmd_addr = 1'b1; cmd_data = 8'h5A; end
      if (nacc >= 2) cmd_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_spacing", t1 - t0, W + 2);
    chk("b2b_ready_low", nlow, W + 1);
    chk("b2b_ready_busy", bad, 0);
    chk("b2b_ry", {24'd0, gpr[0]}, 32'h3C);
    chk("b2b_rx", {24'd0, gpr[1]}, 32'h5A);
    mdl[0] = 8'h3C; mdl[1] = 8'h5A;

    // Randomized commands against the word-level model.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom); a = 1'($urandom); d = W'($urandom);
      if (n % 5 == 0) d = W'($urandom_range(0, 1)) * 8'hFF;
      sum = '0;
      case (op)
        CLR:     nv = '0;
        LOAD:    nv = d;
        ROT:     nv = mdl[a];
        default: begin sum = {1'b0, mdl[a]} + {1'b0, d}; nv = sum[W-1:0]; end
      endcase
      run_check($sformatf("rnd%0d", n), op, a, d, nv, (op == ADD) ? sum[W] : 1'b0, nv == '0);
    end

    // Reset while cnt == 3 aborts without o_done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = LOAD; cmd_addr = 1'b1; cmd_data = 8'hFF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_idle("midreset");
    @(posedge clk); #1;
    chk_idle("midreset_hold");
    @(negedge clk); rst = 1'b0;
    ndn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndn++;
    end
    chk("midreset_nodone", ndn, 0);
    run_check("post_reset_load", LOAD, 1'b1, 8'h77, 8'h77, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
